// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rsa_pkg
//  Description : Shared widths and the modexp sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

  localparam int RSA_LEN = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQUARE = 3'd1,
    MULT   = 3'd2,
    DONE   = 3'd3
  } modexp_state_t;

endpackage
`default_nettype wire

// File: rtl/modexp_ctrl_modmul.sv
`default_nettype none
// ============================================================================
//  Module      : modmul
//  Description : Combinational modular multiplier, res = a*b mod n.
//                Two Montgomery reductions are chained: the first gives
//                a*b*R^-1, the second multiplies by R^2 mod n to cancel the
//                R^-1 factors.  n_prime must equal -n^-1 mod 2^LEN.
//                Inputs a, b must be < n; the output is then < n.
//  Revision    : 1.0 - initial release
// ============================================================================
module modmul #(
  parameter int LEN = 256
) (
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] n,
  input  logic [LEN-1:0] n_prime,
  input  logic [LEN-1:0] r2_mod_n,
  output logic [LEN-1:0] res
);

  // One Montgomery product: x*y*R^-1 mod nn, with a single final subtract.
  function automatic logic [LEN-1:0] mont(
    input logic [LEN-1:0] x,
    input logic [LEN-1:0] y,
    input logic [LEN-1:0] nn,
    input logic [LEN-1:0] np
  );
    logic [2*LEN-1:0] t;
    logic [LEN-1:0]   m;
    logic [2*LEN-1:0] mn;
    logic [LEN:0]     u;
    t  = {{LEN{1'b0}}, x} * {{LEN{1'b0}}, y};
    // m = (t mod R) * n' mod R; the LEN-wide result truncates to mod R
    m  = t[LEN-1:0] * np;
    mn = {{LEN{1'b0}}, m} * {{LEN{1'b0}}, nn};
    // t + m*n is an exact multiple of R; its quotient is < 2n
    u  = (LEN+1)'(({1'b0, t} + {1'b0, mn}) >> LEN);
    if (u >= {1'b0, nn}) begin
      u = u - {1'b0, nn};
    end
    return u[LEN-1:0];
  endfunction

  logic [LEN-1:0] prod_mont;

  // Reduce a*b into Montgomery form, then convert back with R^2.
  always_comb begin
    prod_mont = mont(a, b, n, n_prime);
    res       = mont(prod_mont, r2_mod_n, n, n_prime);
  end

endmodule
`default_nettype wire

// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_ctrl
//  Description : Left-to-right square-and-multiply sequencer computing
//                result = base^exponent mod n with one combinational modmul
//                evaluation per clock.
//                Build option MODEXP_SKIP_LZ_EN: start scanning at the most
//                significant set exponent bit; exponent=0 finishes at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int LEN     = RSA_LEN,
  parameter int EXP_LEN = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN-1:0]     base,
  input  logic [EXP_LEN-1:0] exponent,
  input  logic [LEN-1:0]     n,
  input  logic [LEN-1:0]     n_prime,
  input  logic [LEN-1:0]     r2_mod_n,
  output logic               busy,
  output logic               done,
  output logic [LEN-1:0]     result
);

  localparam int                IDX_W   = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(EXP_LEN - 1);
  localparam logic [LEN-1:0]    ONE     = LEN'(1);

  modexp_state_t      state, state_next;

  logic [LEN-1:0]     acc;
  logic [LEN-1:0]     base_q;
  logic [EXP_LEN-1:0] exp_q;
  logic [LEN-1:0]     n_q;
  logic [LEN-1:0]     np_q;
  logic [LEN-1:0]     r2_q;
  logic [IDX_W-1:0]   idx;
  logic [LEN-1:0]     result_q;

  logic [LEN-1:0]     mm_b;
  logic [LEN-1:0]     mm_res;
  logic [IDX_W-1:0]   start_idx;
  logic               last_bit;

`ifdef MODEXP_SKIP_LZ_EN
  logic               exp_zero;

  // Priority encoder: index of the highest set exponent bit at accept time.
  always_comb begin
    start_idx = '0;
    exp_zero  = 1'b1;
    for (int i = 0; i < EXP_LEN; i++) begin
      if (exponent[i]) begin
        start_idx = IDX_W'(i);
        exp_zero  = 1'b0;
      end
    end
  end
`else
  assign start_idx = IDX_TOP;
`endif

  assign last_bit = (idx == '0);

  // Second modmul operand: acc when squaring, the latched base when multiplying.
  always_comb begin
    mm_b = acc;
    if (state == MULT) begin
      mm_b = base_q;
    end
  end

  modmul #(.LEN(LEN)) u_modmul (
    .a        (acc),
    .b        (mm_b),
    .n        (n_q),
    .n_prime  (np_q),
    .r2_mod_n (r2_q),
    .res      (mm_res)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MODEXP_SKIP_LZ_EN
          state_next = exp_zero ? DONE : SQUARE;
`else
          state_next = SQUARE;
`endif
        end
      end
      SQUARE: begin
        busy = 1'b1;
        if (exp_q[idx]) begin
          state_next = MULT;
        end else if (last_bit) begin
          state_next = DONE;
        end
      end
      MULT: begin
        busy       = 1'b1;
        state_next = last_bit ? DONE : SQUARE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, accumulator, bit index and result register.
  // result is loaded on entry to DONE so it is valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      np_q     <= '0;
      r2_q     <= '0;
      idx      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            n_q    <= n;
            np_q   <= n_prime;
            r2_q   <= r2_mod_n;
            acc    <= ONE;
            idx    <= start_idx;
`ifdef MODEXP_SKIP_LZ_EN
            if (exp_zero) begin
              result_q <= ONE;
            end
`endif
          end
        end
        SQUARE: begin
          acc <= mm_res;
          if (!exp_q[idx]) begin
            if (last_bit) begin
              result_q <= mm_res;
            end else begin
              idx <= idx - IDX_W'(1);
            end
          end
        end
        MULT: begin
          acc <= mm_res;
          if (last_bit) begin
            result_q <= mm_res;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule
`default_nettype wire
